// File: rtl/matrix_display_unit_pkg.sv
// Shared encodings for the matrix display unit: job modes, ASCII bytes and FSM states.
package matrix_display_unit_pkg;

    localparam logic [1:0] DISP_SINGLE = 2'd0;
    localparam logic [1:0] DISP_LIST   = 2'd1;
    localparam logic [1:0] DISP_RECALL = 2'd3;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] SP   = 8'h20;
    localparam logic [7:0] HASH = 8'h23;
    localparam logic [7:0] ZERO = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_HDR,
        S_RD_REQ,
        S_RD_WAIT,
        S_EMIT,
        S_SEP,
        S_DONE,
        S_WAIT_REL
    } state_t;

endpackage

// File: rtl/matrix_display_unit_u8_to_dec_ascii.sv
// Combinational byte-to-decimal converter: three ASCII digits (index 0 = ones) and
// the number of significant digits, so leading zeros can be skipped by the caller.
module u8_to_dec_ascii
    import matrix_display_unit_pkg::*;
(
    input  logic [7:0]      value,
    output logic [2:0][7:0] digits,
    output logic [1:0]      num_digits
);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_digit
            localparam int WEIGHT = 10 ** gi;
            logic [7:0] place;
            assign place      = (value / 8'(WEIGHT)) % 8'd10;
            assign digits[gi] = ZERO + place;
        end
    endgenerate

    assign num_digits = (value >= 8'd100) ? 2'd3 :
                        (value >= 8'd10)  ? 2'd2 : 2'd1;

endmodule

// File: rtl/matrix_display_unit.sv
// Display job responder: validates a job, reads matrix elements from storage and
// streams them as decimal ASCII text (optionally with "#k" headers) to the UART.
module matrix_display_unit
    import matrix_display_unit_pkg::*;
#(
    parameter int MAX_DIM = 5,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [1:0]        total_cnt,
    input  logic [31:0]       dim_m,
    input  logic [31:0]       dim_n,
    input  logic [1:0]        selected_id,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done,
    output logic              err
);

    localparam int DIM_W = $clog2(MAX_DIM + 1);

    state_t            state_reg, state_next;
    logic [DIM_W-1:0]  m_reg, m_next, n_reg, n_next;
    logic [DIM_W-1:0]  r_reg, r_next, c_reg, c_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        k_reg, k_next, last_k_reg, last_k_next;
    logic [7:0]        data_reg, data_next;
    logic [1:0]        hdr_idx_reg, hdr_idx_next;
    logic [1:0]        dig_idx_reg, dig_idx_next;
    logic              sep_idx_reg, sep_idx_next;
    logic              err_reg, err_next;
    logic [DIM_W-1:0]  cache_m_reg, cache_m_next, cache_n_reg, cache_n_next;
    logic [ADDR_W-1:0] cache_base_reg, cache_base_next;
    logic [1:0]        cache_cnt_reg, cache_cnt_next;

    logic [2:0][7:0]   digits;
    logic [1:0]        num_digits;
    logic [1:0]        dig_pos;
    logic              dim_ok;
    logic              job_ok;
    logic [ADDR_W-1:0] recall_off;
    logic              last_col;
    logic              last_row;

    u8_to_dec_ascii u_dec (
        .value      (data_reg),
        .digits     (digits),
        .num_digits (num_digits)
    );

    // Digits are walked most-significant first, starting at the highest significant one.
    assign dig_pos  = num_digits - 2'd1 - dig_idx_reg;
    assign last_col = (c_reg == n_reg - DIM_W'(1));
    assign last_row = (r_reg == m_reg - DIM_W'(1));

    always_comb begin
        dim_ok = (dim_m >= 32'd1) && (dim_m <= 32'(MAX_DIM)) &&
                 (dim_n >= 32'd1) && (dim_n <= 32'(MAX_DIM));
        case (mode)
            DISP_SINGLE: job_ok = dim_ok;
            DISP_LIST:   job_ok = dim_ok && (total_cnt != 2'd0) && (total_cnt <= 2'd2);
            DISP_RECALL: job_ok = dim_ok && (cache_cnt_reg != 2'd0) &&
                                  (selected_id != 2'd0) && (selected_id <= cache_cnt_reg);
            default:     job_ok = 1'b0;
        endcase
        recall_off = ADDR_W'(selected_id - 2'd1) * ADDR_W'(cache_m_reg) * ADDR_W'(cache_n_reg);
    end

    always_comb begin
        state_next      = state_reg;
        m_next          = m_reg;
        n_next          = n_reg;
        r_next          = r_reg;
        c_next          = c_reg;
        addr_next       = addr_reg;
        k_next          = k_reg;
        last_k_next     = last_k_reg;
        data_next       = data_reg;
        hdr_idx_next    = hdr_idx_reg;
        dig_idx_next    = dig_idx_reg;
        sep_idx_next    = sep_idx_reg;
        err_next        = err_reg;
        cache_m_next    = cache_m_reg;
        cache_n_next    = cache_n_reg;
        cache_base_next = cache_base_reg;
        cache_cnt_next  = cache_cnt_reg;
        mem_rd_en       = 1'b0;
        mem_rd_addr     = '0;
        tx_data         = 8'h00;
        tx_valid        = 1'b0;
        done            = 1'b0;
        err             = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (en) state_next = S_CHECK;
            end

            S_CHECK: begin
                err_next     = 1'b0;
                r_next       = '0;
                c_next       = '0;
                hdr_idx_next = '0;
                dig_idx_next = '0;
                sep_idx_next = 1'b0;
                m_next       = dim_m[DIM_W-1:0];
                n_next       = dim_n[DIM_W-1:0];
                addr_next    = base_addr;
                k_next       = 2'd1;
                last_k_next  = 2'd1;
                if (!job_ok) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (mode == DISP_SINGLE) begin
                    state_next = S_RD_REQ;
                end else if (mode == DISP_LIST) begin
                    last_k_next     = total_cnt;
                    cache_m_next    = dim_m[DIM_W-1:0];
                    cache_n_next    = dim_n[DIM_W-1:0];
                    cache_base_next = base_addr;
                    cache_cnt_next  = total_cnt;
                    state_next      = S_HDR;
                end else begin
                    m_next      = cache_m_reg;
                    n_next      = cache_n_reg;
                    addr_next   = cache_base_reg + recall_off;
                    k_next      = selected_id;
                    last_k_next = selected_id;
                    state_next  = S_HDR;
                end
            end

            S_HDR: begin
                tx_valid = 1'b1;
                case (hdr_idx_reg)
                    2'd0:    tx_data = HASH;
                    2'd1:    tx_data = ZERO + {6'd0, k_reg};
                    2'd2:    tx_data = CR;
                    default: tx_data = LF;
                endcase
                if (tx_ready) begin
                    hdr_idx_next = hdr_idx_reg + 2'd1;
                    if (hdr_idx_reg == 2'd3) state_next = S_RD_REQ;
                end
            end

            S_RD_REQ: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = addr_reg;
                state_next  = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                data_next    = mem_rd_data;
                addr_next    = addr_reg + ADDR_W'(1);
                dig_idx_next = '0;
                state_next   = S_EMIT;
            end

            S_EMIT: begin
                tx_valid = 1'b1;
                tx_data  = digits[dig_pos];
                if (tx_ready) begin
                    dig_idx_next = dig_idx_reg + 2'd1;
                    if (dig_pos == 2'd0) state_next = S_SEP;
                end
            end

            S_SEP: begin
                tx_valid = 1'b1;
                if (!last_col) begin
                    tx_data = SP;
                    if (tx_ready) begin
                        c_next     = c_reg + DIM_W'(1);
                        state_next = S_RD_REQ;
                    end
                end else if (!sep_idx_reg) begin
                    tx_data = CR;
                    if (tx_ready) sep_idx_next = 1'b1;
                end else begin
                    tx_data = LF;
                    if (tx_ready) begin
                        sep_idx_next = 1'b0;
                        c_next       = '0;
                        if (!last_row) begin
                            r_next     = r_reg + DIM_W'(1);
                            state_next = S_RD_REQ;
                        end else begin
                            r_next = '0;
                            if (k_reg == last_k_reg) begin
                                state_next = S_DONE;
                            end else begin
                                k_next       = k_reg + 2'd1;
                                hdr_idx_next = '0;
                                state_next   = S_HDR;
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                done       = 1'b1;
                err        = err_reg;
                err_next   = 1'b0;
                state_next = S_WAIT_REL;
            end

            S_WAIT_REL: begin
                if (!en) state_next = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            m_reg          <= '0;
            n_reg          <= '0;
            r_reg          <= '0;
            c_reg          <= '0;
            addr_reg       <= '0;
            k_reg          <= '0;
            last_k_reg     <= '0;
            data_reg       <= '0;
            hdr_idx_reg    <= '0;
            dig_idx_reg    <= '0;
            sep_idx_reg    <= 1'b0;
            err_reg        <= 1'b0;
            cache_m_reg    <= '0;
            cache_n_reg    <= '0;
            cache_base_reg <= '0;
            cache_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            m_reg          <= m_next;
            n_reg          <= n_next;
            r_reg          <= r_next;
            c_reg          <= c_next;
            addr_reg       <= addr_next;
            k_reg          <= k_next;
            last_k_reg     <= last_k_next;
            data_reg       <= data_next;
            hdr_idx_reg    <= hdr_idx_next;
            dig_idx_reg    <= dig_idx_next;
            sep_idx_reg    <= sep_idx_next;
            err_reg        <= err_next;
            cache_m_reg    <= cache_m_next;
            cache_n_reg    <= cache_n_next;
            cache_base_reg <= cache_base_next;
            cache_cnt_reg  <= cache_cnt_next;
        end
    end

endmodule

// File: tb/tb_matrix_display_unit.sv
// Directed bench for matrix_display_unit: a reference model queues expected bytes and
// read addresses per job; a negedge monitor collects what the DUT produces.
module tb_matrix_display_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  base_addr;
    logic [1:0]  total_cnt;
    logic [31:0] dim_m;
    logic [31:0] dim_n;
    logic [1:0]  selected_id;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    matrix_display_unit #(.MAX_DIM(5), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .base_addr   (base_addr),
        .total_cnt   (total_cnt),
        .dim_m       (dim_m),
        .dim_n       (dim_n),
        .selected_id (selected_id),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .done        (done),
        .err         (err)
    );

    logic [7:0] mem [0:255];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit rand_ready = 1'b0;
    bit stall_pend = 1'b0;
    logic [7:0] stall_data;
    logic [7:0] rx_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] saved_q[$];

    int         cache_m = 0, cache_n = 0, cache_cnt = 0;
    logic [7:0] cache_base = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready is chosen at the negedge and held to the next posedge, so a byte seen here
    // with tx_valid && tx_ready is exactly the byte taken at the following edge.
    always @(negedge clk) begin
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall_pend) begin
            check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
            check("tx_hold_data", {24'd0, tx_data}, {24'd0, stall_data});
        end
        stall_pend = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (mem_rd_en) rd_q.push_back(mem_rd_addr);
        if (done) done_cnt++;
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_matrix(input logic [7:0] start, input int m, input int n);
        logic [7:0] a;
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                a = 8'(int'(start) + r * n + c);
                exp_rd_q.push_back(a);
                push_str($sformatf("%0d", mem[a]));
                if (c < n - 1) push_str(" ");
                else push_str("\r\n");
            end
        end
    endtask

    task automatic run_job(input string tag, input logic [1:0] md, input logic [7:0] base,
                           input logic [1:0] cnt, input int m, input int n,
                           input logic [1:0] sel, input bit exp_err);
        int  d0;
        bit  got;
        logic e;
        rx_q.delete(); rd_q.delete(); exp_q.delete(); exp_rd_q.delete();
        if (!exp_err) begin
            if (md == 2'd0) begin
                push_matrix(base, m, n);
            end else if (md == 2'd1) begin
                cache_m = m; cache_n = n; cache_base = base; cache_cnt = int'(cnt);
                for (int k = 1; k <= int'(cnt); k++) begin
                    push_str($sformatf("#%0d\r\n", k));
                    push_matrix(8'(int'(base) + (k - 1) * m * n), m, n);
                end
            end else begin
                push_str($sformatf("#%0d\r\n", sel));
                push_matrix(8'(int'(cache_base) + (int'(sel) - 1) * cache_m * cache_n),
                            cache_m, cache_n);
            end
        end
        @(negedge clk); #1;
        en = 1'b1; mode = md; base_addr = base; total_cnt = cnt;
        dim_m = 32'(m); dim_n = 32'(n); selected_id = sel;
        d0 = done_cnt; got = 1'b0; e = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #1;
            if (done) begin got = 1'b1; e = err; end
        end
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        repeat (6) @(negedge clk);
        #1;
        check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_no_restart"}, {31'd0, tx_valid | mem_rd_en}, 32'd0);
        check({tag, "_byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check({tag, "_byte"}, {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
        check({tag, "_read_count"}, 32'(rd_q.size()), 32'(exp_rd_q.size()));
        while (exp_rd_q.size() > 0 && rd_q.size() > 0)
            check({tag, "_rd_addr"}, {24'd0, rd_q.pop_front()}, {24'd0, exp_rd_q.pop_front()});
        $display("job %s mode=%0d done_seen=%0b err=%0b", tag, md, got, e);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  d0;
        bit  hit;
        rst = 1'b1; en = 1'b0; mode = 2'd0; base_addr = 8'h00; total_cnt = 2'd0;
        dim_m = 32'd0; dim_n = 32'd0; selected_id = 2'd0; tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'd1; mem[8'h11] = 8'd23; mem[8'h12] = 8'd255; mem[8'h13] = 8'd0;
        for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
        mem[8'hFE] = 8'd99; mem[8'hFF] = 8'd100;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {26'd0, mem_rd_en, mem_rd_addr != 8'h0, tx_valid,
                                tx_data != 8'h0, done, err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_job("recall_after_reset", 2'd3, 8'h00, 2'd0, 1, 3, 2'd1, 1'b1);
        run_job("single", 2'd0, 8'h10, 2'd0, 2, 2, 2'd0, 1'b0);
        saved_q.delete();
        push_str("1 23\r\n255 0\r\n");
        saved_q = exp_q; exp_q.delete();
        run_job("list", 2'd1, 8'h00, 2'd2, 1, 3, 2'd0, 1'b0);
        run_job("recall", 2'd3, 8'h40, 2'd0, 4, 3, 2'd2, 1'b0);
        run_job("recall_bad_id", 2'd3, 8'h00, 2'd0, 1, 3, 2'd3, 1'b0 | 1'b1);
        run_job("dim_n_6", 2'd0, 8'h00, 2'd0, 2, 6, 2'd0, 1'b1);
        run_job("mode_2", 2'd2, 8'h00, 2'd0, 2, 2, 2'd0, 1'b1);
        run_job("wrap", 2'd0, 8'hFE, 2'd0, 2, 2, 2'd0, 1'b0);

        // Backpressure: replay the single-matrix job under random ready.
        rand_ready = 1'b1;
        rx_q.delete(); rd_q.delete();
        @(negedge clk); #1;
        en = 1'b1; mode = 2'd0; base_addr = 8'h10; dim_m = 32'd2; dim_n = 32'd2;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk); #1;
            if (done) hit = 1'b1;
        end
        check("stall_done_seen", {31'd0, hit}, 32'd1);
        check("stall_byte_count", 32'(rx_q.size()), 32'(saved_q.size()));
        while (saved_q.size() > 0 && rx_q.size() > 0)
            check("stall_byte", {24'd0, rx_q.pop_front()}, {24'd0, saved_q.pop_front()});
        $display("job stall mode=0 done_seen=%0b", hit);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a list job: no done, outputs cleared, cache gone.
        rx_q.delete();
        @(negedge clk); #1;
        en = 1'b1; mode = 2'd1; base_addr = 8'h00; total_cnt = 2'd2; dim_m = 32'd1; dim_n = 32'd3;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk); #1;
            if (rx_q.size() >= 6) hit = 1'b1;
        end
        check("midjob_progress", {31'd0, hit}, 32'd1);
        d0 = done_cnt;
        rst = 1'b1; en = 1'b0;
        @(negedge clk); #1;
        check("midjob_reset_outputs", {26'd0, mem_rd_en, mem_rd_addr != 8'h0, tx_valid,
                                       tx_data != 8'h0, done, err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midjob_no_done", 32'(done_cnt - d0), 32'd0);
        $display("job midjob_reset bytes_before_reset=%0d", rx_q.size());
        cache_cnt = 0;
        run_job("recall_after_midjob_reset", 2'd3, 8'h00, 2'd0, 1, 3, 2'd1, 1'b1);
        run_job("list_cnt_0", 2'd1, 8'h00, 2'd0, 1, 3, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
